// File: rtl/cen_pkg.sv
// Shared state encodings and width helper for the centering-mean unit.
package cen_pkg;

  typedef logic [1:0] cen_state_t;

  localparam cen_state_t S_IDLE = 2'd0;
  localparam cen_state_t S_ACC  = 2'd1;
  localparam cen_state_t S_DIV  = 2'd2;
  localparam cen_state_t S_OUT  = 2'd3;

  // Accumulator width that holds 2**log2_n full-scale samples without wrapping.
  function automatic int unsigned cen_acc_w(input int unsigned data_w, input int unsigned log2_n);
    return data_w + log2_n;
  endfunction

endpackage

// File: rtl/cen_acc_lane.sv
// One channel of the centering-mean unit: accumulator plus shift-divide into a held mean register.
// Define CEN_MEAN_ROUND_EN to round half up instead of truncating.
module cen_acc_lane
  import cen_pkg::*;
#(
  parameter int unsigned DATA_W = 26,
  parameter int unsigned LOG2_N = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              add,
  input  logic [DATA_W-1:0] din,
  input  logic              div,
  output logic [DATA_W-1:0] mean
);

  localparam int unsigned ACC_W = cen_acc_w(DATA_W, LOG2_N);

  logic [ACC_W-1:0]  r_acc;
  logic [DATA_W-1:0] r_mean;
  logic [ACC_W-1:0]  w_sum;
  logic [DATA_W-1:0] w_mean;

`ifdef CEN_MEAN_ROUND_EN
  localparam logic [ACC_W-1:0] RoundBias = ACC_W'(1) << (LOG2_N - 1);
  // Worst case (2**DATA_W-1)*2**LOG2_N + bias still fits ACC_W.
  assign w_sum = r_acc + RoundBias;
`else
  assign w_sum = r_acc;
`endif

  assign w_mean = DATA_W'(w_sum >> LOG2_N);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc  <= '0;
      r_mean <= '0;
    end else begin
      if (clr) begin
        r_acc <= '0;
      end else if (add) begin
        r_acc <= r_acc + ACC_W'(din);
      end
      if (div) begin
        r_mean <= w_mean;
      end
    end
  end

  assign mean = r_mean;

endmodule

// File: rtl/cen_mean_unit.sv
// Centering-mean unit: block FSM, sample counter and NUM_CH accumulator lanes.
// Optional rounding selected by CEN_MEAN_ROUND_EN (see cen_acc_lane).
module cen_mean_unit
  import cen_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DATA_W = 26,
  parameter int unsigned LOG2_N = 7
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NUM_CH*DATA_W-1:0] out_mean,
  output logic                     busy
);

  cen_state_t        r_state;
  cen_state_t        w_state_nxt;
  logic [LOG2_N-1:0] r_count;
  logic              w_accept;
  logic              w_clr;
  logic              w_add;
  logic              w_div;
  logic              w_last;

  assign in_ready  = (r_state == S_ACC);
  assign out_valid = (r_state == S_OUT);
  assign busy      = (r_state == S_ACC) | (r_state == S_DIV);

  // start aborts any block still in progress but never drops means waiting in S_OUT.
  assign w_accept = in_valid & in_ready;
  assign w_clr    = start & (r_state != S_OUT);
  assign w_add    = w_accept & ~start;
  assign w_div    = (r_state == S_DIV) & ~start;
  assign w_last   = (r_count == {LOG2_N{1'b1}});

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_ACC;
      S_ACC:   if (start) w_state_nxt = S_ACC;
               else if (w_add && w_last) w_state_nxt = S_DIV;
      S_DIV:   w_state_nxt = start ? S_ACC : S_OUT;
      S_OUT:   if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_clr) begin
        r_count <= '0;
      end else if (w_add) begin
        r_count <= r_count + LOG2_N'(1);
      end
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
    cen_acc_lane #(
      .DATA_W(DATA_W),
      .LOG2_N(LOG2_N)
    ) u_lane (
      .clk (clk),
      .rst (rst),
      .clr (w_clr),
      .add (w_add),
      .din (in_data[k*DATA_W +: DATA_W]),
      .div (w_div),
      .mean(out_mean[k*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_cen_mean_unit.sv
// Directed self-checking bench for cen_mean_unit; expectations follow CEN_MEAN_ROUND_EN if defined.
module tb_cen_mean_unit;

  localparam int NUM_CH = 4;
  localparam int DATA_W = 26;
  localparam int N      = 128;
  localparam int VW     = NUM_CH * DATA_W;
  localparam logic [DATA_W-1:0] MaxV = {DATA_W{1'b1}};
`ifdef CEN_MEAN_ROUND_EN
  localparam int HalfUp = 64;  // 8128/128 = 63.5 rounds up
`else
  localparam int HalfUp = 63;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [VW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [VW-1:0] out_mean;
  logic          busy;

  int checks = 0;
  int failures = 0;
  logic [VW-1:0] samples [N];

  always #5 clk = ~clk;

  cen_mean_unit u_dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_mean (out_mean),
    .busy     (busy)
  );

  function automatic logic [VW-1:0] splat(input logic [DATA_W-1:0] v);
    logic [VW-1:0] r;
    for (int k = 0; k < NUM_CH; k++) r[k*DATA_W +: DATA_W] = v;
    return r;
  endfunction

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  // Presents samples[] until all N are accepted; returns on the negedge of the S_DIV cycle.
  task automatic feed_block(input bit gaps);
    int idx = 0;
    int budget = 0;
    while (idx < N && budget < 4000) begin
      @(negedge clk);
      budget++;
      in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_data  = samples[idx];
      if (in_valid && in_ready) idx++;
    end
    if (idx != N) begin
      checks++; failures++;
      $display("FAIL feed_timeout accepted=%0d required=%0d", idx, N);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic take_output();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (out_mean !== '0) begin failures++; $display("FAIL reset_out_mean got=%h exp=0", out_mean); end
  endtask

  task automatic test_constant();
    for (int i = 0; i < N; i++) samples[i] = splat(26'd100);
    pulse_start();
    checks++; if ({busy, in_ready} !== 2'b11) begin failures++; $display("FAIL const_acc_state got=%b exp=11", {busy, in_ready}); end
    feed_block(1'b0);
    checks++; if ({out_valid, busy, in_ready} !== 3'b010) begin failures++; $display("FAIL const_div_cycle got=%b exp=010", {out_valid, busy, in_ready}); end
    @(negedge clk);
    checks++; if ({out_valid, busy} !== 2'b10) begin failures++; $display("FAIL const_latency got=%b exp=10", {out_valid, busy}); end
    for (int k = 0; k < NUM_CH; k++) begin
      checks++;
      if (out_mean[k*DATA_W +: DATA_W] !== 26'd100) begin
        failures++; $display("FAIL const_mean ch=%0d got=%0d exp=100", k, out_mean[k*DATA_W +: DATA_W]);
      end
    end
    take_output();
    checks++; if ({out_valid, busy} !== 2'b00) begin failures++; $display("FAIL const_after_xfer got=%b exp=00", {out_valid, busy}); end
    checks++; if (out_mean !== splat(26'd100)) begin failures++; $display("FAIL const_mean_held got=%h exp=%h", out_mean, splat(26'd100)); end
  endtask

  task automatic test_ramp();
    for (int i = 0; i < N; i++) samples[i] = VW'(i);
    pulse_start();
    feed_block(1'b0);
    @(negedge clk);
    checks++; if (out_mean[DATA_W-1:0] !== 26'(HalfUp)) begin failures++; $display("FAIL ramp_ch0 got=%0d exp=%0d", out_mean[DATA_W-1:0], HalfUp); end
    checks++; if (out_mean[VW-1:DATA_W] !== '0) begin failures++; $display("FAIL ramp_other got=%h exp=0", out_mean[VW-1:DATA_W]); end
    take_output();
  endtask

  task automatic test_max();
    for (int i = 0; i < N; i++) samples[i] = splat(MaxV);
    pulse_start();
    feed_block(1'b0);
    @(negedge clk);
    checks++; if (out_mean !== splat(MaxV)) begin failures++; $display("FAIL max_mean got=%h exp=%h", out_mean, splat(MaxV)); end
    take_output();
  endtask

  task automatic test_stall();
    logic [VW-1:0] exp;
    for (int k = 0; k < NUM_CH; k++) exp[k*DATA_W +: DATA_W] = 26'(k * 1000 + HalfUp);
    for (int i = 0; i < N; i++)
      for (int k = 0; k < NUM_CH; k++) samples[i][k*DATA_W +: DATA_W] = 26'(k * 1000 + i);
    pulse_start();
    feed_block(1'b1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      start = (c == 4);  // must be ignored while means are pending
      checks++;
      if ({out_valid, in_ready} !== 2'b10 || out_mean !== exp) begin
        failures++; $display("FAIL stall_hold cyc=%0d got v=%b r=%b m=%h exp v=1 r=0 m=%h", c, out_valid, in_ready, out_mean, exp);
      end
    end
    start = 1'b0;
    take_output();
    checks++; if ({out_valid, busy} !== 2'b00) begin failures++; $display("FAIL stall_release got=%b exp=00", {out_valid, busy}); end
  endtask

  task automatic test_abort();
    pulse_start();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); in_valid = 1'b1; in_data = splat(26'd99);
    end
    @(negedge clk); start = 1'b1; in_valid = 1'b1; in_data = splat(26'd999);
    @(negedge clk); start = 1'b0; in_valid = 1'b0;
    checks++; if ({busy, in_ready} !== 2'b11) begin failures++; $display("FAIL abort_state got=%b exp=11", {busy, in_ready}); end
    for (int i = 0; i < N; i++) samples[i] = splat(26'd7);
    feed_block(1'b0);
    @(negedge clk);
    checks++; if (out_mean !== splat(26'd7)) begin failures++; $display("FAIL abort_mean got=%h exp=%h", out_mean, splat(26'd7)); end
    take_output();
  endtask

  task automatic test_rst();
    pulse_start();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); in_valid = 1'b1; in_data = splat(26'd5);
    end
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; in_valid = 1'b0;
    checks++; if ({busy, in_ready, out_valid} !== 3'b000) begin failures++; $display("FAIL rst_acc_flags got=%b exp=000", {busy, in_ready, out_valid}); end
    checks++; if (out_mean !== '0) begin failures++; $display("FAIL rst_acc_mean got=%h exp=0", out_mean); end
    for (int i = 0; i < N; i++) samples[i] = splat(26'd100);
    pulse_start();
    feed_block(1'b0);
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL rst_out_reach got=%b exp=1", out_valid); end
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    checks++; if ({out_valid, busy} !== 2'b00 || out_mean !== '0) begin failures++; $display("FAIL rst_out got v=%b b=%b m=%h exp 0", out_valid, busy, out_mean); end
    @(negedge clk); start = 1'b1; rst = 1'b1;
    @(negedge clk); start = 1'b0; rst = 1'b0;
    checks++; if ({busy, in_ready} !== 2'b00) begin failures++; $display("FAIL rst_start_same got=%b exp=00", {busy, in_ready}); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_start_later got=%b exp=0", busy); end
  endtask

  initial begin
    test_reset();
    test_constant();
    test_ramp();
    test_max();
    test_stall();
    test_abort();
    test_rst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
